// File: rtl/comparator_eq.sv
// comparator_eq: 2-bit unsigned equality/magnitude comparator.
// Operand A = {in1,in2}, operand B = {in3,in4}. Exactly one of the
// eq/lt/gt flags is set for any operand pair. OUT_REG selects a
// registered (1-cycle) or purely combinational output path.
module comparator_eq #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  input  logic in4,
  input  logic in_valid,
  output logic out1,
  output logic out_lt,
  output logic out_gt,
  output logic out_valid
);

  logic [1:0] a_p0;
  logic [1:0] b_p0;
  logic [2:0] flags_p0;  // {eq, lt, gt}
  logic       vld_p0;

  // Returns {eq, lt, gt} for two unsigned 2-bit operands.
  function automatic logic [2:0] compare_flags(input logic [1:0] a,
                                               input logic [1:0] b);
    logic [2:0] f;
    f[2] = (a == b);
    f[1] = (a < b);
    f[0] = (a > b);
    return f;
  endfunction

  // Stage p0: operand assembly and compare
  assign a_p0     = {in1, in2};
  assign b_p0     = {in3, in4};
  assign flags_p0 = compare_flags(a_p0, b_p0);
  assign vld_p0   = in_valid;

  generate
    if (OUT_REG) begin : g_reg
      logic [2:0] flags_p1;
      logic       vld_p1;

      // Stage p0 -> p1: valid follows every edge, flags update only on qualified inputs
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          flags_p1 <= 3'b000;
          vld_p1   <= 1'b0;
        end else begin
          vld_p1 <= vld_p0;
          if (vld_p0) begin
            flags_p1 <= flags_p0;
          end
        end
      end

      assign {out1, out_lt, out_gt} = flags_p1;
      assign out_valid              = vld_p1;
    end else begin : g_comb
      // Clock and reset play no part in the zero-latency path.
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign {out1, out_lt, out_gt} = flags_p0;
      assign out_valid              = vld_p0;
    end
  endgenerate

endmodule

// File: tb/tb_comparator_eq.sv
// Scoreboard bench for comparator_eq: registered instance checked through an
// expected-result queue, combinational instance checked directly.
module tb_comparator_eq;

  logic clk;
  logic rst_n;
  logic in1, in2, in3, in4, in_valid;
  logic out1, out_lt, out_gt, out_valid;

  logic c_in1, c_in2, c_in3, c_in4, c_valid;
  logic c_out1, c_lt, c_gt, c_out_valid;

  int checks;
  int failures;
  int cyc;

  typedef struct {
    logic [2:0] flags;  // {eq, lt, gt}
    int         due;
    logic [3:0] code;
  } exp_t;

  exp_t exp_q[$];

  // Hand-computed tables indexed by {in1,in2,in3,in4}
  logic [15:0] eq_tab;
  logic [15:0] lt_tab;
  logic [15:0] gt_tab;

  comparator_eq #(.OUT_REG(1'b1)) dut_reg (
    .clk(clk), .rst_n(rst_n),
    .in1(in1), .in2(in2), .in3(in3), .in4(in4), .in_valid(in_valid),
    .out1(out1), .out_lt(out_lt), .out_gt(out_gt), .out_valid(out_valid)
  );

  comparator_eq #(.OUT_REG(1'b0)) dut_comb (
    .clk(clk), .rst_n(rst_n),
    .in1(c_in1), .in2(c_in2), .in3(c_in3), .in4(c_in4), .in_valid(c_valid),
    .out1(c_out1), .out_lt(c_lt), .out_gt(c_gt), .out_valid(c_out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, req, $time);
    end
  endtask

  // Drive one vector just after a rising edge; push the expectation if qualified.
  task automatic drive(input logic [3:0] code, input logic vld);
    exp_t e;
    @(posedge clk);
    #1;
    {in1, in2, in3, in4} = code;
    in_valid = vld;
    if (vld) begin
      e.flags = {eq_tab[code], lt_tab[code], gt_tab[code]};
      e.due   = cyc + 1;
      e.code  = code;
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compare each qualified output against the queue head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: got flags %b with no pending result (cyc=%0d)",
                   {out1, out_lt, out_gt}, cyc);
        end else begin
          e = exp_q.pop_front();
          if ({out1, out_lt, out_gt} !== e.flags || cyc != e.due) begin
            failures++;
            $display("FAIL result_%b: got flags %b at cyc %0d expected %b at cyc %0d",
                     e.code, {out1, out_lt, out_gt}, cyc, e.flags, e.due);
          end
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missing_%b: got out_valid %b expected 1 at cyc %0d",
                 e.code, out_valid, e.due);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    eq_tab = 16'h8421;  // 0000,0101,1010,1111
    lt_tab = 16'h08CE;  // 0001,0010,0011,0110,0111,1011
    gt_tab = 16'h7310;  // 0100,1000,1001,1100,1101,1110
    checks = 0;
    failures = 0;
    cyc = 0;
    rst_n = 1'b0;
    {in1, in2, in3, in4} = 4'b0000;
    in_valid = 1'b1;
    {c_in1, c_in2, c_in3, c_in4} = 4'b0000;
    c_valid = 1'b0;

    // Reset value: A=B=0 with valid asserted must still read all zero
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_flags", {1'b0, out1, out_lt, out_gt}, 4'b0000);
      check("reset_valid", {3'b000, out_valid}, 4'b0000);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Exhaustive sweep, back-to-back
    for (int c = 0; c < 16; c++) drive(4'(c), 1'b1);

    // Hold: qualified 0101 then unqualified 0110
    drive(4'b0101, 1'b1);
    drive(4'b0110, 1'b0);
    @(posedge clk);
    #1;
    check("hold_eq", {1'b0, out1, out_lt, out_gt}, 4'b0100);
    check("hold_valid", {3'b000, out_valid}, 4'b0000);

    // Async reset mid-stream while out1=1 and out_valid=1
    drive(4'b1111, 1'b1);
    @(posedge clk);
    #3;
    check("pre_reset", {out1, out_lt, out_gt, out_valid}, 4'b1001);
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_reset", {out1, out_lt, out_gt, out_valid}, 4'b0000);
    @(posedge clk);
    #1;
    check("reset_held", {out1, out_lt, out_gt, out_valid}, 4'b0000);
    rst_n = 1'b1;
    drive(4'b1111, 1'b1);
    drive(4'b0000, 1'b0);

    // Back-to-back eq, lt, gt
    drive(4'b1010, 1'b1);
    drive(4'b1011, 1'b1);
    drive(4'b1001, 1'b1);
    drive(4'b0000, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 4'(exp_q.size()), 4'd0);

    // Combinational instance: no clock edge between stimulus and check
    @(negedge clk);
    #1;
    {c_in1, c_in2, c_in3, c_in4} = 4'b0011;
    c_valid = 1'b1;
    #1;
    check("comb_lt", {c_out1, c_lt, c_gt, c_out_valid}, 4'b0101);
    {c_in1, c_in2, c_in3, c_in4} = 4'b1100;
    c_valid = 1'b0;
    #1;
    check("comb_gt", {c_out1, c_lt, c_gt, c_out_valid}, 4'b0010);
    rst_n = 1'b0;
    {c_in1, c_in2, c_in3, c_in4} = 4'b1010;
    c_valid = 1'b1;
    #1;
    check("comb_eq_in_reset", {c_out1, c_lt, c_gt, c_out_valid}, 4'b1001);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
